// File: rtl/serial_add_unit_if.sv
// serial_add_unit_if
//   Request/response bundle for the bit-serial add/subtract unit.
//   master: issues start/sub/a/b and observes busy/done/result/flags.
//   slave : the arithmetic unit itself.
interface serial_add_unit_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;

  modport master (
    output start, sub, a, b,
    input  busy, done, result, flags
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, result, flags
  );
endinterface

// File: rtl/serial_add_unit.sv
// adder
//   1-bit full adder: s = a ^ b ^ cin, cout = majority(a, b, cin).
module adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// serial_add_unit
//   Bit-serial add/subtract engine, one operand bit pair per clock, LSB
//   first, through a single full adder. Produces a WIDTH-bit result and
//   ARM-style {N,Z,C,V} flags once per operation.
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous, active-high reset
//     bus    slave side of serial_add_unit_if (start/sub/a/b in,
//            busy/done/result/flags out)
//
//   state | meaning
//   ------+--------------------------------------------------------
//   IDLE  | waiting for start; result/flags hold last values
//   RUN   | shifting WIDTH bit pairs through the adder, busy=1
//   DONE  | one-cycle done pulse; start here reloads straight into RUN
module serial_add_unit #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  serial_add_unit_if.slave  bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh, res_next;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             sum, cout;
  logic             last_bit;
  logic             load;

  adder u_adder (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .s    (sum),
    .cout (cout)
  );

  assign last_bit = (cnt == CW'(WIDTH - 1));
  assign res_next = {sum, res_sh[WIDTH-1:1]};
  // start is only honoured when no operation is in flight
  assign load     = bus.start && (state == IDLE || state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    bus.busy   = 1'b0;
    bus.done   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) state_next = RUN;
      end
      RUN: begin
        bus.busy = 1'b1;
        if (last_bit) state_next = DONE;
      end
      DONE: begin
        bus.done   = 1'b1;
        state_next = bus.start ? RUN : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_sh       <= '0;
      b_sh       <= '0;
      res_sh     <= '0;
      cnt        <= '0;
      carry      <= 1'b0;
      bus.result <= '0;
      bus.flags  <= '0;
    end else if (load) begin
      // subtraction as a + ~b + 1: invert b and seed the carry with 1
      a_sh   <= bus.a;
      b_sh   <= bus.b ^ {WIDTH{bus.sub}};
      carry  <= bus.sub;
      cnt    <= '0;
      res_sh <= '0;
    end else if (state == RUN) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      carry  <= cout;
      cnt    <= cnt + CW'(1);
      res_sh <= res_next;
      // visible result/flags change only once the whole word is formed;
      // on the MSB step, carry is Cin_MSB and cout is Cout_MSB
      if (last_bit) begin
        bus.result <= res_next;
        bus.flags  <= {sum, (res_next == '0), cout, carry ^ cout};
      end
    end
  end
endmodule

// File: tb/tb_serial_add_unit.sv
`timescale 1ns/1ps
module tb_serial_add_unit;
  localparam int W = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  int   busy_cnt = 0;

  typedef struct packed {
    logic [W-1:0] res;
    logic [3:0]   flg;
  } exp_t;
  exp_t sb[$];

  serial_add_unit_if #(.WIDTH(W)) bus ();

  serial_add_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: pops the scoreboard on every done pulse
  always @(negedge clk) begin
    if (reset) begin
      busy_cnt = 0;
    end else begin
      if (bus.busy) busy_cnt++;
      if (bus.busy && bus.done) check("busy_done_overlap", 1, 0);
      if (bus.done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("result", {24'd0, bus.result}, {24'd0, e.res});
          check("flags", {28'd0, bus.flags}, {28'd0, e.flg});
          check("busy_cycles", busy_cnt, W);
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                       input logic [W-1:0] er, input logic [3:0] ef, input bit expect_done);
    bus.a = a; bus.b = b; bus.sub = sub; bus.start = 1'b1;
    if (expect_done) sb.push_back({er, ef});
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1;
        break;
      end
    end
    if (!seen) check({"timeout_", name}, 0, 1);
  endtask

  initial begin
    bus.start = 1'b0; bus.sub = 1'b0; bus.a = '0; bus.b = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // idle after reset
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("idle_out", {bus.busy, bus.done, bus.flags, bus.result}, 14'h0);
    end

    issue(8'h05, 8'h03, 1'b0, 8'h08, 4'b0000, 1); wait_done("add_05_03"); @(negedge clk);
    issue(8'h7F, 8'h01, 1'b0, 8'h80, 4'b1001, 1); wait_done("add_7f_01"); @(negedge clk);
    issue(8'hFF, 8'h01, 1'b0, 8'h00, 4'b0110, 1); wait_done("add_ff_01"); @(negedge clk);
    issue(8'h05, 8'h05, 1'b1, 8'h00, 4'b0110, 1); wait_done("sub_05_05"); @(negedge clk);
    issue(8'h03, 8'h05, 1'b1, 8'hFE, 4'b1000, 1); wait_done("sub_03_05"); @(negedge clk);
    issue(8'h80, 8'h01, 1'b1, 8'h7F, 4'b0011, 1); wait_done("sub_80_01"); @(negedge clk);
    check("hold_in_idle", {24'd0, bus.result}, 32'h7F);

    // start during RUN is ignored; inputs change while busy
    issue(8'h10, 8'h20, 1'b0, 8'h30, 4'b0000, 1);
    @(negedge clk);
    issue(8'hAA, 8'h55, 1'b1, 8'h00, 4'b0000, 0);
    check("hold_during_run", {24'd0, bus.result}, 32'h7F);
    wait_done("add_10_20");
    // back-to-back: start presented in DONE
    issue(8'h01, 8'h01, 1'b0, 8'h02, 4'b0000, 1);
    check("b2b_busy", bus.busy, 1);
    check("b2b_hold", {24'd0, bus.result}, 32'h30);
    wait_done("add_01_01"); @(negedge clk);

    // reset mid-run discards the operation
    issue(8'hF0, 8'h0F, 1'b0, 8'h00, 4'b0000, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("reset_out", {bus.busy, bus.done, bus.flags, bus.result}, 14'h0);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    check("no_done_after_reset", {bus.busy, bus.done, bus.flags, bus.result}, 14'h0);
    issue(8'h02, 8'h02, 1'b0, 8'h04, 4'b0000, 1); wait_done("add_02_02"); @(negedge clk);

    check("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
